// File: rtl/seven_segment_capture.sv
// Samples a multiplexed, active-low seven-segment bus, turns each stable digit
// back into a hex nibble and presents the assembled word on a valid/ready port.
module seven_segment_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic [1:0]            err,
    input  logic                  err_clr,
    output logic [7:0]            err_cnt
);

    localparam int                BUS_W   = DIGITS + 7;
    localparam logic [7:0]        CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]        CNT_CAP = 8'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] AN_ONE  = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [BUS_W-1:0]    s1_reg, s2_reg, p_reg;
    logic [7:0]          cnt_reg, cnt_next;
    logic                eq, cap;

    logic [DIGITS-1:0]   an_low;
    logic [6:0]          seg_s;
    logic                an_blank, an_single, an_multi;
    logic [3:0]          dec_nibble;
    logic                dec_ok;

    logic [DIGITS-1:0]   wr_en;
    logic [3:0]          slot_reg [DIGITS];
    logic [4*DIGITS-1:0] slot_word;
    logic [DIGITS-1:0]   seen_reg, seen_next;
    logic                frame_full, load;

    logic [4*DIGITS-1:0] value_reg;
    logic                valid_reg;
    logic [1:0]          err_reg, err_next;
    logic                set_inv, set_multi;
    logic [7:0]          err_cnt_reg;

    // Two-flop synchronizer plus one extra delay stage for the equality test;
    // reset loads the idle bus (all lines high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg <= '1;
            s2_reg <= '1;
            p_reg  <= '1;
        end else begin
            s1_reg <= {an_in, seg_in};
            s2_reg <= s1_reg;
            p_reg  <= s2_reg;
        end
    end

    assign eq = (s2_reg == p_reg);

    // Saturating at CNT_MAX keeps cap from re-firing until the bus changes.
    always_comb begin
        cnt_next = cnt_reg;
        if (!eq)
            cnt_next = '0;
        else if (cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign cap = eq && (cnt_reg == CNT_CAP);

    assign an_low    = ~s2_reg[BUS_W-1:7];
    assign seg_s     = s2_reg[6:0];
    assign an_blank  = (an_low == '0);
    assign an_single = !an_blank && ((an_low & (an_low - AN_ONE)) == '0);
    assign an_multi  = !an_blank && !an_single;

    always_comb begin
        dec_nibble = 4'h0;
        dec_ok     = 1'b1;
        unique case (seg_s)
            7'h40:   dec_nibble = 4'h0;
            7'h79:   dec_nibble = 4'h1;
            7'h24:   dec_nibble = 4'h2;
            7'h30:   dec_nibble = 4'h3;
            7'h19:   dec_nibble = 4'h4;
            7'h12:   dec_nibble = 4'h5;
            7'h02:   dec_nibble = 4'h6;
            7'h78:   dec_nibble = 4'h7;
            7'h00:   dec_nibble = 4'h8;
            7'h10:   dec_nibble = 4'h9;
            7'h08:   dec_nibble = 4'hA;
            7'h03:   dec_nibble = 4'hB;
            7'h46:   dec_nibble = 4'hC;
            7'h21:   dec_nibble = 4'hD;
            7'h06:   dec_nibble = 4'hE;
            7'h0E:   dec_nibble = 4'hF;
            default: dec_ok     = 1'b0;
        endcase
    end

    assign set_inv   = cap && an_single && !dec_ok;
    assign set_multi = cap && an_multi;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign wr_en[gi]             = cap && an_single && dec_ok && an_low[gi];
            assign slot_word[4*gi +: 4]  = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++)
                slot_reg[i] <= 4'h0;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (wr_en[i])
                    slot_reg[i] <= dec_nibble;
        end
    end

    // A capture on the load edge belongs to the next frame, so its seen bit
    // is ORed in after the clear.
    assign frame_full = &seen_reg;
    assign load       = frame_full && (!valid_reg || value_ready);
    assign seen_next  = (load ? '0 : seen_reg) | wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n)
            seen_reg <= '0;
        else
            seen_reg <= seen_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_reg <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            value_reg <= slot_word;
            valid_reg <= 1'b1;
        end else if (valid_reg && value_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // A clear and a new error on the same edge leave that error bit set.
    assign err_next = (err_clr ? 2'b00 : err_reg) | {set_multi, set_inv};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg     <= 2'b00;
            err_cnt_reg <= 8'h00;
        end else begin
            err_reg <= err_next;
            if (set_inv && (err_cnt_reg != 8'hFF))
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign value_out   = value_reg;
    assign value_valid = valid_reg;
    assign err         = err_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized bench for seven_segment_capture; a run-length/transaction model
// of the display bus predicts captured words, errors and handshake state.
module tb_seven_segment_capture;

    localparam int D = 4;
    localparam int S = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [6:0]   seg_in;
    logic [D-1:0] an_in;
    logic [W-1:0] value_out;
    logic         value_valid;
    logic         value_ready;
    logic [1:0]   err;
    logic         err_clr;
    logic [7:0]   err_cnt;

    seven_segment_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .err         (err),
        .err_clr     (err_clr),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: what the display has shown, not how the RTL stores it.
    logic [3:0]   m_slot [D];
    logic [D-1:0] m_seen;
    logic [W-1:0] m_out;
    logic         m_valid;
    logic [1:0]   m_err;
    int           m_errcnt;
    logic [D+6:0] m_prev;
    int           m_run;
    bit           m_captured;

    function automatic int decode(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == seg) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_slot[i] = 4'h0;
        m_seen = '0; m_out = '0; m_valid = 1'b0; m_err = 2'b00; m_errcnt = 0;
        m_prev = '1; m_run = 1000; m_captured = 1'b1;
    endtask

    task automatic model_load();
        for (int j = 0; j < D; j++) m_out[4*j +: 4] = m_slot[j];
        m_valid = 1'b1;
        m_seen  = '0;
    endtask

    task automatic model_capture(input logic [D-1:0] an, input logic [6:0] seg);
        int lows = 0;
        int k = 0;
        int nib;
        for (int i = 0; i < D; i++)
            if (!an[i]) begin lows++; k = i; end
        if (lows == 0) return;
        if (lows > 1) begin m_err[1] = 1'b1; return; end
        nib = decode(seg);
        if (nib < 0) begin
            m_err[0] = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
            return;
        end
        m_slot[k] = nib[3:0];
        m_seen[k] = 1'b1;
        if (&m_seen && (!m_valid || value_ready)) model_load();
        if (value_ready) m_valid = 1'b0;
    endtask

    // A pattern is captured once it has been on the bus for S+1 cycles in a row.
    task automatic model_hold(input logic [D-1:0] an, input logic [6:0] seg, input int n);
        if ({an, seg} == m_prev) m_run += n;
        else begin m_prev = {an, seg}; m_run = n; m_captured = 1'b0; end
        if (!m_captured && m_run >= S + 1) begin
            m_captured = 1'b1;
            model_capture(an, seg);
        end
    endtask

    task automatic drive(input logic [D-1:0] an, input logic [6:0] seg, input int n);
        model_hold(an, seg, n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        drive('1, 7'h7F, 10);
    endtask

    function automatic logic [D-1:0] digit_an(input int k);
        logic [D-1:0] an;
        an = '1;
        an[k] = 1'b0;
        return an;
    endfunction

    task automatic scan(input logic [W-1:0] w, input logic [D-1:0] mask, input int n);
        for (int k = 0; k < D; k++)
            if (mask[k]) drive(digit_an(k), seg_tab[w[4*k +: 4]], n);
    endtask

    task automatic consume();
        if (&m_seen) model_load();
        else m_valid = 1'b0;
        value_ready = 1'b1;
        drive(an_in, seg_in, 1);
        value_ready = 1'b0;
    endtask

    task automatic pulse_err_clr();
        m_err = 2'b00;
        err_clr = 1'b1;
        drive(an_in, seg_in, 1);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; an_in = '1; seg_in = 7'h7F; value_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (value_out !== '0) begin n_mis++; $display("FAIL reset_out: got %h expected 0", value_out); end
        n_vec++; if (value_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", value_valid); end
        n_vec++; if (err !== 2'b00) begin n_mis++; $display("FAIL reset_err: got %b expected 00", err); end
        n_vec++; if (err_cnt !== 8'h00) begin n_mis++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        value_ready = 1'b0;
        scan(16'h3210, '1, 10);
        settle();
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL basic_out: got %h expected %h", value_out, m_out); end
        n_vec++; if (value_out !== 16'h3210) begin n_mis++; $display("FAIL basic_word: got %h expected 3210", value_out); end
        n_vec++; if (value_valid !== 1'b1) begin n_mis++; $display("FAIL basic_valid: got %b expected 1", value_valid); end
        n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL basic_err: got %b expected %b", err, m_err); end
        consume();
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL basic_consume: got %b expected %b", value_valid, m_valid); end
        $display("test_basic done: value_out=%h", value_out);
    endtask

    task automatic test_timing();
        logic [W-1:0] w;
        w = W'($urandom);
        value_ready = 1'b0;
        scan(w, 4'b0111, 10);
        model_hold(digit_an(3), seg_tab[w[15:12]], S + 5);
        an_in  = digit_an(3);
        seg_in = seg_tab[w[15:12]];
        repeat (S + 3) @(negedge clk);
        n_vec++; if (value_valid !== 1'b0) begin n_mis++; $display("FAIL timing_early: got %b expected 0 after edge %0d", value_valid, S + 3); end
        @(negedge clk);
        n_vec++; if (value_valid !== 1'b1) begin n_mis++; $display("FAIL timing_rise: got %b expected 1 after edge %0d", value_valid, S + 4); end
        @(negedge clk);
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL timing_out: got %h expected %h", value_out, m_out); end
        settle();
        consume();
        $display("test_timing done: word=%h", w);
    endtask

    task automatic test_glitch();
        logic [W-1:0] w;
        logic [3:0]   lo;
        w = W'($urandom);
        value_ready = 1'b0;
        drive(digit_an(0), 7'h19, 3);
        drive(digit_an(0), 7'h12, 10);
        scan(w, 4'b1110, 10);
        settle();
        lo = value_out[3:0];
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL glitch_out: got %h expected %h", value_out, m_out); end
        n_vec++; if (lo !== 4'h5) begin n_mis++; $display("FAIL glitch_slot0: got %h expected 5", lo); end
        consume();
        pulse_err_clr();
        drive(digit_an(0), 7'h7F, S);
        settle();
        n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL run_short: got %b expected %b", err, m_err); end
        drive(digit_an(0), 7'h7F, S + 1);
        settle();
        n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL run_exact: got %b expected %b", err, m_err); end
        n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_mis++; $display("FAIL run_errcnt: got %0d expected %0d", err_cnt, m_errcnt); end
        $display("test_glitch done: err=%b err_cnt=%0d", err, err_cnt);
    endtask

    task automatic test_random();
        logic [D-1:0] an;
        logic [6:0]   seg;
        int r, i, j;
        value_ready = 1'b1;
        for (int h = 1; h <= 120; h++) begin
            r = int'($urandom_range(0, 9));
            i = int'($urandom_range(0, D - 1));
            if (r == 0) begin
                an = '1; seg = 7'($urandom);
            end else if (r == 1) begin
                j = (i + 1 + int'($urandom_range(0, D - 2))) % D;
                an = D'($urandom); an[i] = 1'b0; an[j] = 1'b0; seg = 7'($urandom);
            end else if (r == 2) begin
                an = digit_an(i);
                do seg = 7'($urandom); while (decode(seg) >= 0);
            end else begin
                an = digit_an(i); seg = seg_tab[$urandom_range(0, 15)];
            end
            drive(an, seg, int'($urandom_range(1, S + 6)));
            if (h % 20 == 0) begin
                settle();
                n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL rand_out: got %h expected %h", value_out, m_out); end
                n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL rand_valid: got %b expected %b", value_valid, m_valid); end
                n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL rand_err: got %b expected %b", err, m_err); end
                n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_mis++; $display("FAIL rand_errcnt: got %0d expected %0d", err_cnt, m_errcnt); end
                $display("random block %0d: value_out=%h err=%b err_cnt=%0d", h / 20, value_out, err, err_cnt);
            end
        end
        value_ready = 1'b0;
        pulse_err_clr();
    endtask

    task automatic test_invalid();
        logic [W-1:0] w;
        w = W'($urandom);
        value_ready = 1'b0;
        pulse_err_clr();
        drive(digit_an(0), seg_tab[7], 10);
        drive(digit_an(0), 7'h7F, S + 1);
        settle();
        n_vec++; if (err !== 2'b01) begin n_mis++; $display("FAIL inv_err: got %b expected 01", err); end
        n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_mis++; $display("FAIL inv_errcnt: got %0d expected %0d", err_cnt, m_errcnt); end
        for (int n = 0; n < 300; n++) begin
            drive(digit_an(0), 7'h7F, S + 1);
            drive('1, 7'h7F, 1);
        end
        settle();
        n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_mis++; $display("FAIL inv_saturate: got %0d expected %0d", err_cnt, m_errcnt); end
        pulse_err_clr();
        n_vec++; if (err !== 2'b00) begin n_mis++; $display("FAIL inv_clear: got %b expected 00", err); end
        n_vec++; if (err_cnt !== 8'hFF) begin n_mis++; $display("FAIL inv_cnt_kept: got %0d expected 255", err_cnt); end
        scan(w, 4'b1110, 10);
        settle();
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL inv_slot0: got %h expected %h", value_out, m_out); end
        consume();
        $display("test_invalid done: err_cnt=%0d value_out=%h", err_cnt, value_out);
    endtask

    task automatic test_multi();
        logic [W-1:0] w;
        w = W'($urandom);
        value_ready = 1'b0;
        pulse_err_clr();
        drive(4'b1100, seg_tab[1], 10);
        scan(w, 4'b1110, 10);
        settle();
        n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL multi_err: got %b expected %b", err, m_err); end
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL multi_noseen: got %b expected %b", value_valid, m_valid); end
        pulse_err_clr();
        drive(4'b1111, seg_tab[2], 10);
        settle();
        n_vec++; if (err !== m_err) begin n_mis++; $display("FAIL blank_err: got %b expected %b", err, m_err); end
        scan(w, 4'b0001, 10);
        settle();
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL multi_frame_valid: got %b expected %b", value_valid, m_valid); end
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL multi_frame_out: got %h expected %h", value_out, m_out); end
        consume();
        $display("test_multi done: value_out=%h", value_out);
    endtask

    task automatic test_back_to_back();
        value_ready = 1'b0;
        scan(16'hABCD, '1, 10);
        settle();
        scan(16'h1234, '1, 10);
        settle();
        n_vec++; if (value_out !== 16'hABCD) begin n_mis++; $display("FAIL bp_hold: got %h expected abcd", value_out); end
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL bp_valid: got %b expected %b", value_valid, m_valid); end
        consume();
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL bp_next: got %h expected %h", value_out, m_out); end
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL bp_next_valid: got %b expected %b", value_valid, m_valid); end
        drive('1, 7'h7F, 3);
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL bp_stall: got %b expected %b", value_valid, m_valid); end
        consume();
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL bp_drain: got %b expected %b", value_valid, m_valid); end
        $display("test_back_to_back done: value_out=%h", value_out);
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] w;
        w = W'($urandom);
        value_ready = 1'b0;
        scan(W'($urandom), 4'b0011, 10);
        do_reset();
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL mid_out: got %h expected %h", value_out, m_out); end
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL mid_valid: got %b expected %b", value_valid, m_valid); end
        n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_mis++; $display("FAIL mid_errcnt: got %0d expected %0d", err_cnt, m_errcnt); end
        scan(w, '1, 10);
        settle();
        n_vec++; if (value_out !== m_out) begin n_mis++; $display("FAIL mid_frame: got %h expected %h", value_out, m_out); end
        consume();
        settle();
        n_vec++; if (value_valid !== m_valid) begin n_mis++; $display("FAIL mid_single: got %b expected %b", value_valid, m_valid); end
        $display("test_reset_midrun done: word=%h", w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; an_in = '1; seg_in = 7'h7F; value_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_timing();
        test_glitch();
        test_random();
        test_invalid();
        test_multi();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
